// File: rtl/fft_delay_commutator.sv
// Two-lane delay-commutator stage for the streaming FFT datapath.
// Reorders lane samples so pairs leave as time-aligned butterfly operands.
// Optional flush port enabled by defining FFT_COMMUTATOR_FLUSH_EN.
module fft_delay_commutator #(
  parameter int DATA_W = 32,
  parameter int DELAY  = 4,
  parameter int CNT_W  = $clog2(2*DELAY)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FFT_COMMUTATOR_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              sel
);

  localparam int PRIME_W = $clog2(DELAY+1);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(DELAY);

  logic              flush_req;
  logic              accept;
  logic              phase;
  logic [CNT_W-1:0]  cnt;
  logic [PRIME_W-1:0] prime_cnt;
  logic [DATA_W-1:0] dly_a [DELAY];
  logic [DATA_W-1:0] dly_b [DELAY];
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [DATA_W-1:0] s0;
  logic [DATA_W-1:0] s1;

`ifdef FFT_COMMUTATOR_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // A flush cycle swallows whatever sample is presented alongside it.
  assign accept = in_valid & ~flush_req;
  assign phase  = cnt[CNT_W-1];
  assign a_out  = dly_a[DELAY-1];
  assign b_out  = dly_b[DELAY-1];

  // Swap network: phase 0 passes in0 straight to s0, phase 1 exchanges it with the delayed in1.
  always_comb begin
    s0 = in0;
    s1 = b_out;
    if (phase) begin
      s0 = b_out;
      s1 = in0;
    end
  end

  // Delay lines shift only on accepted samples and are never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int i = DELAY-1; i >= 1; i--) begin
        dly_a[i] <= dly_a[i-1];
        dly_b[i] <= dly_b[i-1];
      end
      dly_a[0] <= s0;
      dly_b[0] <= in1;
    end
  end

  // Sample counter and saturating prime count; flush restarts both without touching data.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_req) begin
      cnt       <= '0;
      prime_cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (prime_cnt != PRIME_MAX) begin
        prime_cnt <= prime_cnt + 1'b1;
      end
    end
  end

  // Output register: new pair on every accepted sample, valid only once primed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      sel       <= 1'b0;
    end else if (flush_req) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= (prime_cnt == PRIME_MAX);
      out0      <= a_out;
      out1      <= s1;
      sel       <= phase;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_delay_commutator.sv
// Self-checking bench for fft_delay_commutator with DELAY=4 and DELAY=1 instances
// driven by the same stream and compared against an index-based reference model.
module tb_fft_delay_commutator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in0, in1;

  logic        v4, s4, v1, s1;
  logic [31:0] o0_4, o1_4, o0_1, o1_1;

  int total = 0;
  int bad   = 0;

  // Reference history: accepted samples since the last reset or flush.
  logic [31:0] h0 [256];
  logic [31:0] h1 [256];
  int          n_acc = 0;

  // Expected output state per instance (index 0: DELAY=4, index 1: DELAY=1).
  int          dval [2] = '{4, 1};
  logic [31:0] e_o0 [2];
  logic [31:0] e_o1 [2];
  logic        e_sel [2];
  logic        e_val [2];
  logic        e_known [2];

  always #5 clk = ~clk;

  fft_delay_commutator #(.DATA_W(32), .DELAY(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef FFT_COMMUTATOR_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in0(in0), .in1(in1),
    .out_valid(v4), .out0(o0_4), .out1(o1_4), .sel(s4)
  );

  fft_delay_commutator #(.DATA_W(32), .DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef FFT_COMMUTATOR_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in0(in0), .in1(in1),
    .out_valid(v1), .out0(o0_1), .out1(o1_1), .sel(s1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int phase_of(int d, int j);
    return (j / d) % 2;
  endfunction

  // s0 of accepted sample j for depth d, straight from the swap rule.
  function automatic logic [31:0] s0_of(int d, int j);
    if (phase_of(d, j) == 0) return h0[j];
    return h1[j - d];
  endfunction

  task automatic compareAll();
    logic [31:0] a0 [2];
    logic [31:0] a1 [2];
    logic        av [2];
    logic        as [2];
    a0[0] = o0_4; a1[0] = o1_4; av[0] = v4; as[0] = s4;
    a0[1] = o0_1; a1[1] = o1_1; av[1] = v1; as[1] = s1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("d%0d_valid", dval[u]), {31'd0, av[u]}, {31'd0, e_val[u]});
      checkOutput($sformatf("d%0d_sel", dval[u]), {31'd0, as[u]}, {31'd0, e_sel[u]});
      if (e_known[u]) begin
        checkOutput($sformatf("d%0d_out0", dval[u]), a0[u], e_o0[u]);
        checkOutput($sformatf("d%0d_out1", dval[u]), a1[u], e_o1[u]);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic f, input logic r);
    int k;
    @(negedge clk);
    in_valid = v; in0 = a; in1 = b; flush = f; rst_n = r;
    @(posedge clk);
    #1;
    if (!r) begin
      n_acc = 0;
      for (int u = 0; u < 2; u++) begin
        e_val[u] = 1'b0; e_sel[u] = 1'b0; e_o0[u] = '0; e_o1[u] = '0; e_known[u] = 1'b1;
      end
`ifdef FFT_COMMUTATOR_FLUSH_EN
    end else if (f) begin
      n_acc = 0;
      for (int u = 0; u < 2; u++) e_val[u] = 1'b0;
`endif
    end else if (v) begin
      k = n_acc;
      h0[k] = a;
      h1[k] = b;
      n_acc++;
      for (int u = 0; u < 2; u++) begin
        e_sel[u] = phase_of(dval[u], k) != 0;
        e_val[u] = k >= dval[u];
        e_known[u] = e_val[u];
        if (e_val[u]) begin
          e_o0[u] = s0_of(dval[u], k - dval[u]);
          e_o1[u] = (phase_of(dval[u], k) == 0) ? h1[k - dval[u]] : h0[k];
        end
      end
    end else begin
      for (int u = 0; u < 2; u++) e_val[u] = 1'b0;
    end
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0;
    doReset();
    doReset();

    // DELAY=1 directed pairs.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'hA0 + k, 32'hB0 + k, 1'b0, 1'b1);
      if (k == 1) begin
        checkOutput("d1_k1_out0", o0_1, 32'hA0);
        checkOutput("d1_k1_out1", o1_1, 32'hA1);
        checkOutput("d1_k1_sel", {31'd0, s1}, 32'd1);
      end
      if (k == 2) begin
        checkOutput("d1_k2_out0", o0_1, 32'hB0);
        checkOutput("d1_k2_out1", o1_1, 32'hB1);
        checkOutput("d1_k2_sel", {31'd0, s1}, 32'd0);
      end
    end
    doReset();

    // Directed 16-sample stream, back to back.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 32'h100 + k, 32'h200 + k, 1'b0, 1'b1);
      if (k == 4) begin
        checkOutput("d4_k4_out0", o0_4, 32'h100);
        checkOutput("d4_k4_out1", o1_4, 32'h104);
      end
      if (k == 8) begin
        checkOutput("d4_k8_out0", o0_4, 32'h200);
        checkOutput("d4_k8_out1", o1_4, 32'h204);
      end
      if (k == 12) begin
        checkOutput("d4_k12_out0", o0_4, 32'h108);
        checkOutput("d4_k12_out1", o1_4, 32'h10C);
      end
    end
    doReset();

    // Same stream with three bubbles after every sample.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 32'h100 + k, 32'h200 + k, 1'b0, 1'b1);
      for (int b = 0; b < 3; b++) applyStimulus(1'b0, $urandom, $urandom, 1'b0, 1'b1);
    end

    // Keep streaming to exercise counter wrap many times.
    for (int k = 0; k < 40; k++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1);

    // Mid-stream reset with a sample presented during reset.
    doReset();
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1);

`ifdef FFT_COMMUTATOR_FLUSH_EN
    // Flush after k=9, with a sample presented in the flush cycle.
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    applyStimulus(1'b1, $urandom, $urandom, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1);
      if (k == 4) checkOutput("d4_flush_sel", {31'd0, s4}, 32'd1);
    end
`endif

    // Random traffic with occasional bubbles, resets and flushes.
    for (int c = 0; c < 600; c++) begin
      logic r, f, v;
      r = !(($urandom_range(0, 79) == 0) || (n_acc >= 250));
      f = 1'b0;
`ifdef FFT_COMMUTATOR_FLUSH_EN
      f = ($urandom_range(0, 59) == 0);
`endif
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, $urandom, $urandom, f, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
